// File: rtl/shot_pkg.sv
// rtl/shot_pkg.sv - shared shot types, board bounds and counter helpers
package shot_pkg;

  typedef enum logic [2:0] {READY, REQUEST, FLIGHT, KILL, RELOAD} fire_state_t;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} shot_dir_t;

  localparam int unsigned BOARD_X_MIN = 32;
  localparam int unsigned BOARD_X_MAX = 600;
  localparam int unsigned BOARD_Y_MIN = 160;
  localparam int unsigned BOARD_Y_MAX = 456;

  localparam int unsigned CNT_W = 8;

  function automatic logic [CNT_W-1:0] sat_cnt(input int unsigned v);
    return (v > 32'd255) ? 8'd255 : v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// rtl/frame_down_counter.sv - frame-count down counter with load and zero flag
module frame_down_counter
  import shot_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  input  logic             startOfFrame,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_d, count_q;

  // Stops at zero so a late startOfFrame cannot wrap the count.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && startOfFrame && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/shot_fire_ctrl.sv
// rtl/shot_fire_ctrl.sv - one-shot fire request, shot hit detection and reload timing
module shot_fire_ctrl
  import shot_pkg::*;
#(
  parameter int unsigned RELOAD_FRAMES      = 45,
  parameter int unsigned ACK_TIMEOUT_FRAMES = 2,
  parameter int unsigned BOARD_MIN_X        = BOARD_X_MIN,
  parameter int unsigned BOARD_MAX_X        = BOARD_X_MAX,
  parameter int unsigned BOARD_MIN_Y        = BOARD_Y_MIN,
  parameter int unsigned BOARD_MAX_Y        = BOARD_Y_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        game_enable,
  input  logic        fire_key,
  input  logic        shot_alive,
  input  logic [10:0] shot_topLeftX,
  input  logic [10:0] shot_topLeftY,
  input  logic        drawing_request_shot,
  input  logic        drawing_request_wall,
  input  logic        drawing_request_monster,
  output logic        fire_pressed,
  output logic        fireCollision,
  output logic        monster_hit,
  output logic        reload_active,
  output logic [7:0]  reload_left
);

  if (RELOAD_FRAMES > 255 || ACK_TIMEOUT_FRAMES > 255) begin : g_param_range
    $error("shot_fire_ctrl: frame counts must fit in 8 bits");
  end

  localparam logic [10:0] MIN_X = 11'(BOARD_MIN_X);
  localparam logic [10:0] MAX_X = 11'(BOARD_MAX_X);
  localparam logic [10:0] MIN_Y = 11'(BOARD_MIN_Y);
  localparam logic [10:0] MAX_Y = 11'(BOARD_MAX_Y);
  localparam logic [CNT_W-1:0] RELOAD_LOAD = sat_cnt(RELOAD_FRAMES);
  localparam logic [CNT_W-1:0] ACK_LOAD    = sat_cnt(ACK_TIMEOUT_FRAMES);

  fire_state_t state_d, state_q;
  logic fire_key_d, fire_key_q;
  logic fire_key_prev_d, fire_key_prev_q;
  logic wall_hit_d, wall_hit_q;
  logic mon_hit_d, mon_hit_q;
  logic monster_hit_d, monster_hit_q;

  logic             ack_load, rel_load;
  logic [CNT_W-1:0] ack_count, rel_count;
  logic             ack_zero, rel_zero;
  logic             fire_edge, wall_seen, mon_seen, out_of_bounds;

  assign fire_edge = fire_key_q & ~fire_key_prev_q;
  assign wall_seen = wall_hit_q | (drawing_request_shot & drawing_request_wall);
  assign mon_seen  = mon_hit_q | (drawing_request_shot & drawing_request_monster);
  // Unsigned on purpose: a shot wrapped past zero reads as a huge coordinate.
  assign out_of_bounds = (shot_topLeftX < MIN_X) || (shot_topLeftX > MAX_X) ||
                         (shot_topLeftY < MIN_Y) || (shot_topLeftY > MAX_Y);

  always_comb begin
    state_d         = state_q;
    fire_key_d      = fire_key;
    fire_key_prev_d = fire_key_q;
    wall_hit_d      = 1'b0;
    mon_hit_d       = 1'b0;
    monster_hit_d   = 1'b0;
    ack_load        = 1'b0;
    rel_load        = 1'b0;
    case (state_q)
      READY: begin
        if (fire_edge && game_enable && !shot_alive) begin
          state_d  = REQUEST;
          ack_load = 1'b1;
        end
      end
      REQUEST: begin
        if (shot_alive) begin
          state_d = FLIGHT;
        end else if (ack_zero || (startOfFrame && ack_count == 8'd1)) begin
          state_d = READY;
        end
      end
      FLIGHT: begin
        wall_hit_d = wall_seen;
        mon_hit_d  = mon_seen;
        if (startOfFrame) begin
          wall_hit_d = 1'b0;
          mon_hit_d  = 1'b0;
          if (wall_seen || mon_seen || out_of_bounds) begin
            state_d       = KILL;
            monster_hit_d = mon_seen;
          end else if (!shot_alive) begin
            state_d  = RELOAD;
            rel_load = 1'b1;
          end
        end else if (!shot_alive) begin
          state_d  = RELOAD;
          rel_load = 1'b1;
        end
      end
      KILL: begin
        if (!shot_alive) begin
          state_d  = RELOAD;
          rel_load = 1'b1;
        end
      end
      RELOAD: begin
        if (rel_zero || (startOfFrame && rel_count == 8'd1)) begin
          state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= READY;
      fire_key_q      <= 1'b0;
      fire_key_prev_q <= 1'b0;
      wall_hit_q      <= 1'b0;
      mon_hit_q       <= 1'b0;
      monster_hit_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      fire_key_q      <= fire_key_d;
      fire_key_prev_q <= fire_key_prev_d;
      wall_hit_q      <= wall_hit_d;
      mon_hit_q       <= mon_hit_d;
      monster_hit_q   <= monster_hit_d;
    end
  end

  frame_down_counter u_ack_cnt (
    .clk          (clk),
    .reset        (reset),
    .load         (ack_load),
    .load_value   (ACK_LOAD),
    .enable       (state_q == REQUEST),
    .startOfFrame (startOfFrame),
    .count        (ack_count),
    .zero         (ack_zero)
  );

  frame_down_counter u_reload_cnt (
    .clk          (clk),
    .reset        (reset),
    .load         (rel_load),
    .load_value   (RELOAD_LOAD),
    .enable       (state_q == RELOAD),
    .startOfFrame (startOfFrame),
    .count        (rel_count),
    .zero         (rel_zero)
  );

  assign fire_pressed  = (state_q == REQUEST);
  assign fireCollision = (state_q == KILL);
  assign monster_hit   = monster_hit_q;
  assign reload_active = (state_q == RELOAD);
  assign reload_left   = reload_active ? rel_count : 8'd0;

endmodule
